// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Also provides flush, a sticky halt lock and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e             r_state,     w_state_next;
    logic [DATA_W-1:0]  r_main_data, w_main_data_next;
    logic [DATA_W-1:0]  r_skid_data, w_skid_data_next;
    logic               r_main_halt, w_main_halt_next;
    logic               r_skid_halt, w_skid_halt_next;
    logic               r_halt_lock, w_halt_lock_next;
    logic [CNT_W-1:0]   r_stall_cnt, w_stall_cnt_next;
    logic               w_acc;
    logic               w_drn;

    // Handshake outputs depend on registered state only; no out_ready -> in_ready path.
    assign out_valid = (r_state != StEmpty);
    assign in_ready  = (r_state != StTwo) && !r_halt_lock;
    assign out_data  = r_main_data;
    assign out_halt  = r_main_halt;
    assign stall_cnt = r_stall_cnt;

    assign w_acc = in_valid & in_ready;
    assign w_drn = out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_main_data_next = r_main_data;
        w_main_halt_next = r_main_halt;
        w_skid_data_next = r_skid_data;
        w_skid_halt_next = r_skid_halt;
        w_halt_lock_next = r_halt_lock;
        w_stall_cnt_next = r_stall_cnt;

        if (flush) begin
            w_state_next     = StEmpty;
            w_main_data_next = '0;
            w_main_halt_next = 1'b0;
            w_skid_data_next = '0;
            w_skid_halt_next = 1'b0;
            w_halt_lock_next = 1'b0;
        end else begin
            if (w_acc && in_halt) begin
                w_halt_lock_next = 1'b1;
            end
            case (r_state)
                StEmpty: begin
                    if (w_acc) begin
                        w_state_next     = StOne;
                        w_main_data_next = in_data;
                        w_main_halt_next = in_halt;
                    end
                end
                StOne: begin
                    if (w_acc && w_drn) begin
                        w_main_data_next = in_data;
                        w_main_halt_next = in_halt;
                    end else if (w_acc) begin
                        w_state_next     = StTwo;
                        w_skid_data_next = in_data;
                        w_skid_halt_next = in_halt;
                    end else if (w_drn) begin
                        w_state_next     = StEmpty;
                        w_main_data_next = '0;
                        w_main_halt_next = 1'b0;
                    end
                end
                StTwo: begin
                    if (w_drn) begin
                        w_state_next     = StOne;
                        w_main_data_next = r_skid_data;
                        w_main_halt_next = r_skid_halt;
                        w_skid_data_next = '0;
                        w_skid_halt_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next     = StEmpty;
                    w_main_data_next = '0;
                    w_main_halt_next = 1'b0;
                    w_skid_data_next = '0;
                    w_skid_halt_next = 1'b0;
                end
            endcase
        end

        // Counter is independent of flush; clear wins over increment.
        if (clr_cnt) begin
            w_stall_cnt_next = '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != CntMax)) begin
            w_stall_cnt_next = r_stall_cnt + CntOne;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= StEmpty;
            r_main_data <= '0;
            r_main_halt <= 1'b0;
            r_skid_data <= '0;
            r_skid_halt <= 1'b0;
            r_halt_lock <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_main_data <= w_main_data_next;
            r_main_halt <= w_main_halt_next;
            r_skid_data <= w_skid_data_next;
            r_skid_halt <= w_skid_halt_next;
            r_halt_lock <= w_halt_lock_next;
            r_stall_cnt <= w_stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_halt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_halt;
    logic              flush;
    logic              clr_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_halt   (in_halt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_halt  (out_halt),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              h;
    } ent_t;

    ent_t        m_q[$];
    logic        m_lock;
    int unsigned m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge: drive, compare, advance model across the posedge.
    task automatic step(input logic iv, input logic [63:0] id, input logic ih,
                        input logic ordy, input logic fl, input logic clr, input logic rst);
        logic m_valid, m_ready, acc, drn;
        RST = rst; in_valid = iv; in_data = id; in_halt = ih;
        out_ready = ordy; flush = fl; clr_cnt = clr;
        #1;
        m_valid = (m_q.size() > 0);
        m_ready = (m_q.size() < 2) && !m_lock;
        check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        check_eq("in_ready",  {63'd0, in_ready},  {63'd0, m_ready});
        check_eq("out_data",  out_data, m_valid ? m_q[0].d : 64'd0);
        check_eq("out_halt",  {63'd0, out_halt}, {63'd0, (m_valid ? m_q[0].h : 1'b0)});
        check_eq("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
        acc = iv & m_ready;
        drn = m_valid & ordy;
        @(posedge CLK);
        if (rst) begin
            m_q.delete();
            m_lock = 1'b0;
            m_cnt  = 0;
        end else begin
            if (clr) m_cnt = 0;
            else if (m_valid && !ordy && m_cnt < 15) m_cnt++;
            if (fl) begin
                m_q.delete();
                m_lock = 1'b0;
            end else begin
                if (drn) void'(m_q.pop_front());
                if (acc) begin
                    m_q.push_back('{d: id, h: ih});
                    if (ih) m_lock = 1'b1;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, ordy, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_data = '0; in_halt = 1'b0;
        out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        m_lock = 1'b0; m_cnt = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);

        // Streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Backpressure into the skid entry, then drain in order
        step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Flush while full, with a coincident incoming word
        step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);

        // Halt lock: 0x6 must never be accepted until flush
        step(1'b1, 64'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 64'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1);

        // Counter saturation, clear, then resume
        step(1'b1, 64'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 20);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 2);

        // Reset while full with an incoming word
        step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 99) == 0);
        end
        idle(1'b1, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the five-stage core; successor to the fixed-field stage latches.
- Carries an opaque DATA_W payload between adjacent stages using a valid/ready handshake instead of global ihit/dhit enables.
- Includes a 2-entry skid buffer, so in_ready is registered and there is no combinational path from out_ready.
- Also provides flush (squash), a sticky halt lock and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 64, payload width in bits (control bits, data, wsel, pc+4 packed by the instantiating stage).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream stage presents a word.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  DATA_W  upstream payload.
- in_halt  input  1  word is a halt instruction.
- out_valid  output  1  word available to the downstream stage.
- out_ready  input  1  downstream stage consumes the word this cycle.
- out_data  output  DATA_W  payload of the head entry.
- out_halt  output  1  halt flag of the head entry.
- flush  input  1  squash all held words (branch/jump resolved).
- clr_cnt  input  1  clear the stall counter.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage:
  - main entry (data, halt) drives out_data/out_halt.
  - skid entry (data, halt) is the overflow slot.
  - State is EMPTY, ONE or TWO.
- Definitions:
  - acc = in_valid & in_ready.
  - drn = out_valid & out_ready.
- Outputs (all derived from registered state only):
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO) & !halt_lock.
- Reset: state EMPTY, out_valid 0, in_ready 1, out_data 0, out_halt 0, halt_lock 0, stall_cnt 0. RST mid-transfer discards both entries; an acc coincident with RST is dropped.
- Transitions (when flush=0, RST=0):
  - EMPTY: acc -> ONE, main <= in.
  - ONE: acc&drn -> ONE, main <= in. acc&!drn -> TWO, skid <= in. drn&!acc -> EMPTY. Neither -> hold.
  - TWO: drn -> ONE, main <= skid (skid cleared to 0). No acc is possible (in_ready=0). No drn -> hold.
- Latency: 1 cycle from acc into EMPTY to out_valid. Sustained throughput is 1 word/cycle when out_ready is held high.
- Ordering: strict FIFO. The skid word is never output before the main word.
- Payload integrity: out_data must not change while out_valid=1 and out_ready=0.
- Flush: highest priority after RST. Next cycle state is EMPTY, both entries are zeroed and halt_lock clears.
  - An acc in the flush cycle is discarded.
  - A drn in the flush cycle still counts as consumed downstream; the stage does not regenerate it.
- Halt lock:
  - acc with in_halt=1 sets halt_lock, which forces in_ready=0.
  - The halt word drains normally with out_halt=1.
  - Only RST or flush clears halt_lock.
- Stall counter:
  - Increments by 1 on each cycle where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt sets it to 0, taking priority over the increment.
  - Flush does not clear it.
- Unused entries hold 0. Width rules: payload is passed bit-exact, with no sign or width conversion.

Test Plan:
1. Streaming: RST, then in_valid=1 with data 1..8 on consecutive cycles, out_ready=1 -> out_data 1..8 on cycles 1..8 after each input, in_ready stays 1, stall_cnt=0.
2. Backpressure/skid: feed A=0xA, B=0xB with out_ready=0 -> state TWO, in_ready=0 from the cycle after B, out_data=0xA held. Raise out_ready -> A then B out in order, in_ready returns to 1 one cycle after the first drain. stall_cnt=number of stalled cycles.
3. Flush in TWO: hold A,B with out_ready=0, assert flush together with in_valid (data 0xC) -> next cycle out_valid=0, in_ready=1, 0xC never appears at the output.
4. Halt: send 0x5 with in_halt=1, then in_valid=1 with 0x6 -> 0x5 emitted with out_halt=1. in_ready stays 0 and 0x6 is never accepted until flush or RST.
5. Counter saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15. Pulse clr_cnt -> 0 next cycle, then resumes counting.
6. Reset mid-operation: state TWO, assert RST for 1 cycle with in_valid=1 -> out_valid=0, in_ready=1, out_data=0, stall_cnt=0 after the edge.
